// File: rtl/formula_pkg.sv
// Shared widths and the result type for the formula pipeline.
// Imported by the formula block, its result buffer and the bench.
// No logic here: constants and typedefs only.
package formula_pkg;

    localparam int FORMULA_WIDTH     = 8;
    localparam int FORMULA_WIDTH_OUT = 2*FORMULA_WIDTH + 6;
    localparam int DROP_CNT_W        = 16;

    typedef logic signed [FORMULA_WIDTH_OUT-1:0] result_t;

endpackage

// File: rtl/formula_fifo_mem.sv
// DEPTH x WIDTH_OUT result storage: synchronous write, asynchronous read.
// Latency: write visible on rdata the cycle after we; read is combinational.
// Backpressure: none; the caller only asserts we when a slot is free.
module formula_fifo_mem #(
    parameter int DEPTH     = 8,
    parameter int WIDTH_OUT = 22,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH_OUT-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [WIDTH_OUT-1:0] rdata
);

    logic [WIDTH_OUT-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/formula_result_buffer.sv
// Buffers formula results (no upstream backpressure) and re-presents them FWFT on valid/ready.
// Latency: an entry pushed at edge N appears on vld_out/q_out after edge N; no same-cycle bypass.
// Backpressure: consumer stalls via rdy_out; when full, incoming results are dropped and counted.
module formula_result_buffer
    import formula_pkg::*;
#(
    parameter int  WIDTH     = FORMULA_WIDTH,
    parameter int  WIDTH_OUT = 2*WIDTH + 6,
    parameter int  DEPTH     = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vld_in,
    input  logic signed [WIDTH_OUT-1:0] q_in,
    output logic                        vld_out,
    input  logic                        rdy_out,
    output logic signed [WIDTH_OUT-1:0] q_out,
    output logic [ADDR_W:0]             level,
    output logic [ADDR_W:0]             peak,
    output logic                        overflow,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);

    localparam logic [ADDR_W:0]     PTR_ONE = 1;
    localparam logic [DROP_CNT_W-1:0] CNT_ONE = 1;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] level_nxt;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    // Extra MSB on the pointers distinguishes full from empty when addresses match.
    assign full = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign pop  = vld_out & rdy_out;
    assign push = vld_in & (~full | pop);
    assign drop = vld_in & full & ~pop;

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + PTR_ONE;
        end else if (pop && !push) begin
            level_nxt = level - PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            peak     <= '0;
            vld_out  <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level   <= level_nxt;
            vld_out <= (level_nxt != '0);
            if (level_nxt > peak) begin
                peak <= level_nxt;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_ONE;
                end
            end
        end
    end

    formula_fifo_mem #(
        .DEPTH     (DEPTH),
        .WIDTH_OUT (WIDTH_OUT),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (q_in),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (q_out)
    );

endmodule

// File: tb/tb_formula_result_buffer.sv
// Directed bench for formula_result_buffer (DEPTH=8): reset, pass-through, fill/drop,
// full push+pop, wrap with toggling ready, and reset mid-burst.
module tb_formula_result_buffer;
    import formula_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            vld_in;
    result_t         q_in;
    logic            vld_out;
    logic            rdy_out;
    result_t         q_out;
    logic [3:0]      level;
    logic [3:0]      peak;
    logic            overflow;
    logic [15:0]     drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    formula_result_buffer #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .q_in     (q_in),
        .vld_out  (vld_out),
        .rdy_out  (rdy_out),
        .q_out    (q_out),
        .level    (level),
        .peak     (peak),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int model[$];
        int expd[8];
        int n_out;

        // Reset held two cycles with a live strobe.
        rst = 1'b1; vld_in = 1'b1; q_in = 7; rdy_out = 1'b0;
        tick(); tick();
        chk("rst_vld", 32'(vld_out), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_peak", 32'(peak), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b0; vld_in = 1'b0;

        // Pass-through with no same-cycle bypass.
        rdy_out = 1'b1; vld_in = 1'b1; q_in = -5;
        #1 chk("pt_nobypass", 32'(vld_out), 0);
        tick();
        chk("pt_vld1", 32'(vld_out), 1);
        chk("pt_q1", q_out, -5);
        chk("pt_lvl1", 32'(level), 1);
        q_in = 1234;
        tick();
        chk("pt_q2", q_out, 1234);
        chk("pt_lvl2", 32'(level), 1);
        vld_in = 1'b0;
        tick();
        chk("pt_empty", 32'(vld_out), 0);
        chk("pt_peak", 32'(peak), 1);

        // Empty FIFO with ready high: nothing pops.
        tick();
        chk("empty_rdy_lvl", 32'(level), 0);

        // Fill with consumer stalled; the last two results drop.
        rdy_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vld_in = 1'b1; q_in = result_t'(i);
            tick();
            if (i == 7) chk("fill8_drop", 32'(drop_cnt), 0);
        end
        vld_in = 1'b0;
        chk("fill_lvl", 32'(level), 8);
        chk("fill_peak", 32'(peak), 8);
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_drop", 32'(drop_cnt), 2);

        // Full with simultaneous push and pop.
        vld_in = 1'b1; q_in = 99; rdy_out = 1'b1;
        #1 chk("fp_head", q_out, 0);
        tick();
        vld_in = 1'b0; rdy_out = 1'b0;
        chk("fp_lvl", 32'(level), 8);
        chk("fp_drop", 32'(drop_cnt), 2);
        tick();
        chk("stall_q", q_out, 1);

        expd = '{1, 2, 3, 4, 5, 6, 7, 99};
        rdy_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_vld", 32'(vld_out), 1);
            chk("drain_q", q_out, expd[i]);
            tick();
        end
        rdy_out = 1'b0;
        chk("drain_done", 32'(vld_out), 0);
        chk("drain_lvl", 32'(level), 0);

        // Wrap: 24 pushes in 48 cycles, ready toggling every cycle.
        n_out = 0;
        for (int i = 0; i < 48; i++) begin
            rdy_out = i[0];
            vld_in  = i[1];
            q_in    = result_t'(100 + i);
            #1;
            chk("wrap_vld", 32'(vld_out), (model.size() != 0) ? 1 : 0);
            if (vld_out && rdy_out && model.size() != 0) begin
                chk("wrap_q", q_out, model.pop_front());
                n_out++;
            end
            if (vld_in) model.push_back(100 + i);
            tick();
        end
        vld_in = 1'b0; rdy_out = 1'b1;
        for (int i = 0; i < 16 && model.size() != 0; i++) begin
            #1;
            if (vld_out) begin
                chk("wrap_tail_q", q_out, model.pop_front());
                n_out++;
            end
            tick();
        end
        chk("wrap_count", n_out, 24);
        chk("wrap_drop", 32'(drop_cnt), 2);

        // Reset mid-burst discards stored entries.
        rdy_out = 1'b0; vld_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q_in = result_t'(200 + i);
            tick();
        end
        chk("mid_lvl5", 32'(level), 5);
        rst = 1'b1; q_in = 555;
        tick();
        rst = 1'b0; vld_in = 1'b0;
        chk("mid_vld", 32'(vld_out), 0);
        chk("mid_lvl", 32'(level), 0);
        chk("mid_peak", 32'(peak), 0);
        chk("mid_drop", 32'(drop_cnt), 0);
        vld_in = 1'b1; q_in = 42;
        tick();
        vld_in = 1'b0;
        chk("post_vld", 32'(vld_out), 1);
        chk("post_q", q_out, 42);
        chk("post_lvl", 32'(level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
